meta_write_responder: RTL and testbench
=======================================

# meta_write_responder

Responder at the far end of the cache metadata-write arbitration path. It accepts one arbitrated write request (set index, way enable, tag, source id). It performs the write into a local tag/valid array, then returns a per-source acknowledgement to the requester that won arbitration. Fixed to three sources, which matches the three-input metadata-write arbiter upstream; a combinational read port serves tag lookups.

## Interface
Parameters:
- IDX_W, 7, set-index width; array depth SETS = 2^IDX_W (128).
- TAG_W, 20, stored tag width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- io_in_valid  in  1  arbitrated request valid.
- io_in_ready  out  1  request accepted when high with io_in_valid.
- io_in_bits_idx  in  IDX_W  target set.
- io_in_bits_way_en  in  1  1 = write tag, 0 = no-op write (still acknowledged).
- io_in_bits_tag  in  TAG_W  tag to store.
- io_in_chosen  in  2  source id from arbiter (0..2 legal).
- io_resp_0_valid / io_resp_1_valid / io_resp_2_valid  out  1 each  ack to source 0/1/2.
- io_resp_0_ready / io_resp_1_ready / io_resp_2_ready  in  1 each  source accepts ack.
- io_resp_bits_idx  out  IDX_W  idx of the acknowledged write (shared by all sources).
- io_rd_idx  in  IDX_W  lookup set.
- io_rd_valid  out  1  stored valid bit at io_rd_idx.
- io_rd_tag  out  TAG_W  stored tag at io_rd_idx.
- io_busy  out  1  high when FSM not IDLE.
- io_err  out  1  sticky: a request with io_in_chosen==3 was accepted.

## Operation
- Storage: SETS entries of {valid, tag}. Valid bits are cleared by reset_n. Tags are not reset.
- FSM states: IDLE, WRITE, RESP.
  - IDLE: io_in_ready=1. On io_in_valid: capture idx, way_en, tag, chosen into holding registers, then go to WRITE.
  - WRITE: if way_en=1, set entry[idx] = {1, tag}. If chosen==3, set io_err and go to IDLE (no ack). Otherwise go to RESP.
  - RESP: assert io_resp_<chosen>_valid only; io_resp_bits_idx = captured idx. When the matching io_resp_<chosen>_ready is high, go to IDLE. Ready inputs of non-selected sources are ignored.
- io_in_ready=0 in WRITE and RESP; no request is accepted outside IDLE.
- Ack stability: ack valid and idx are held stable until the handshake completes, no matter how long ready stays low.
- Read port: purely combinational from the array (see Configuration for the WRITE-cycle case).
- io_err: cleared only by reset_n.
- Reset (async, any state, including mid-RESP): FSM=IDLE, all io_resp_*_valid=0, io_busy=0, io_err=0, all valid bits=0, holding registers=0.

## Timing
- Output reset values: io_in_ready=1, io_resp_*_valid=0, io_resp_bits_idx=0, io_busy=0, io_err=0, io_rd_valid=0.
- Cycle timeline for a request accepted at edge E0:
  - E0+1: array updated.
  - From E0+1 to E0+2: io_resp valid high.
  - Earliest ack handshake: E0+2.
  - io_in_ready high again: the cycle after the ack handshake.
- Minimum spacing between accepted requests: 3 cycles.
- io_rd_* reflect an array write from the cycle after the WRITE state.
- Ready held low in RESP: state is held indefinitely; no timeout.

## Configuration
- META_RESP_BYPASS_EN defined: a lookup made during WRITE with io_rd_idx == captured idx and way_en=1 returns io_rd_valid=1 and io_rd_tag = captured tag (write-first forwarding).
- META_RESP_BYPASS_EN undefined: a lookup made during WRITE returns the pre-write array contents. The new value is visible from the next cycle.

## Test plan
- Reset, then io_rd_idx sweep 0..127 -> io_rd_valid=0 everywhere. io_in_ready=1, io_busy=0.
- Request idx=0x15, way_en=1, tag=0xABCDE, chosen=1, with io_resp_1_ready=1 -> io_resp_1_valid high for one cycle at E0+2 with idx=0x15, io_resp_0/2_valid stay 0. io_rd_idx=0x15 afterwards gives valid=1, tag=0xABCDE.
- Request chosen=2, way_en=0, io_resp_2_ready held low 10 cycles -> io_resp_2_valid held 10+ cycles, io_in_ready=0 throughout, array unchanged. io_resp_1_ready pulses during this window are ignored.
- Request chosen=3 -> no ack asserted, io_err=1 and sticky; FSM back to IDLE after 2 cycles.
- reset_n asserted while in RESP -> io_resp_*_valid drop immediately (async), io_err=0, entry 0x15 reads valid=0.
- Lookup of idx=0x7F during its own WRITE cycle with tag=0x12345 -> returns 0x12345/valid=1 with META_RESP_BYPASS_EN defined, old contents without it.

Source files
------------

// File: rtl/meta_write_responder.sv
// meta_write_responder
//
// Far-end responder of the cache metadata-write arbitration path. It takes one
// arbitrated request (set index, way enable, tag, source id). It writes the
// request into a local {valid, tag} array. It then acknowledges the source that
// won arbitration. Three sources are supported, which matches the upstream
// three-input arbiter. A combinational read port serves tag lookups.
//
// Optional feature macro: META_RESP_BYPASS_EN
//   defined   - a lookup made during the WRITE cycle that hits the captured idx
//               (with way_en=1) returns the tag being written (write-first).
//   undefined - a lookup made during WRITE sees the pre-write contents.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   io_in_valid / io_in_ready         request handshake (ready only in IDLE)
//   io_in_bits_idx/way_en/tag         request payload
//   io_in_chosen                      winning source id (0..2 legal, 3 = error)
//   io_resp_<n>_valid / _ready        per-source acknowledgement handshake
//   io_resp_bits_idx                  idx of the acknowledged write
//   io_rd_idx -> io_rd_valid/io_rd_tag combinational lookup
//   io_busy                           FSM not in IDLE
//   io_err                            sticky: a request with chosen==3 was taken

module meta_write_responder #(
  parameter int IDX_W = 7,
  parameter int TAG_W = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [IDX_W-1:0] io_in_bits_idx,
  input  logic             io_in_bits_way_en,
  input  logic [TAG_W-1:0] io_in_bits_tag,
  input  logic [1:0]       io_in_chosen,
  output logic             io_resp_0_valid,
  output logic             io_resp_1_valid,
  output logic             io_resp_2_valid,
  input  logic             io_resp_0_ready,
  input  logic             io_resp_1_ready,
  input  logic             io_resp_2_ready,
  output logic [IDX_W-1:0] io_resp_bits_idx,
  input  logic [IDX_W-1:0] io_rd_idx,
  output logic             io_rd_valid,
  output logic [TAG_W-1:0] io_rd_tag,
  output logic             io_busy,
  output logic             io_err
);

  localparam int SETS = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;

  logic [IDX_W-1:0] hold_idx;
  logic             hold_way_en;
  logic [TAG_W-1:0] hold_tag;
  logic [1:0]       hold_chosen;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_mem [SETS];

  logic [2:0]       resp_valid_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             err_q;

  logic [2:0]       resp_ready;
  logic             ack_done;

  assign resp_ready = {io_resp_2_ready, io_resp_1_ready, io_resp_0_ready};

  // resp_valid_q is one-hot on the captured source. Masking with it means
  // that readies from sources that are not being acknowledged have no effect.
  assign ack_done = |(resp_valid_q & resp_ready);

  // The control FSM. The valid bits live here because reset must clear them.
  // All visible handshake/status outputs are registered alongside the state,
  // so they are glitch-free and drop at the same moment reset hits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hold_idx     <= '0;
      hold_way_en  <= 1'b0;
      hold_tag     <= '0;
      hold_chosen  <= 2'd0;
      valid_q      <= '0;
      resp_valid_q <= 3'b000;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid) begin
            hold_idx    <= io_in_bits_idx;
            hold_way_en <= io_in_bits_way_en;
            hold_tag    <= io_in_bits_tag;
            hold_chosen <= io_in_chosen;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (hold_way_en) begin
            valid_q[hold_idx] <= 1'b1;
          end
          // Source id 3 has no ack channel. Flag the error and return to IDLE.
          if (hold_chosen == 2'd3) begin
            err_q      <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end else begin
            resp_valid_q <= 3'b001 << hold_chosen;
            state        <= RESP;
          end
        end
        RESP: begin
          if (ack_done) begin
            resp_valid_q <= 3'b000;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 3'b000;
          in_ready_q   <= 1'b1;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Tag storage is deliberately left without a reset. Only the valid bits are
  // meaningful after reset, so the tag memory can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == WRITE && hold_way_en) begin
      tag_mem[hold_idx] <= hold_tag;
    end
  end

  // The lookup port is purely combinational from the array. With the bypass
  // enabled, an in-flight WRITE to the same set is forwarded so that a reader
  // never sees the stale value in that cycle.
  always_comb begin
    io_rd_valid = valid_q[io_rd_idx];
    io_rd_tag   = tag_mem[io_rd_idx];
`ifdef META_RESP_BYPASS_EN
    if (state == WRITE && hold_way_en && io_rd_idx == hold_idx) begin
      io_rd_valid = 1'b1;
      io_rd_tag   = hold_tag;
    end
`endif
  end

  assign io_in_ready      = in_ready_q;
  assign io_resp_0_valid  = resp_valid_q[0];
  assign io_resp_1_valid  = resp_valid_q[1];
  assign io_resp_2_valid  = resp_valid_q[2];
  assign io_resp_bits_idx = hold_idx;
  assign io_busy          = busy_q;
  assign io_err           = err_q;

endmodule

// File: tb/tb_meta_write_responder.sv
// tb_meta_write_responder
//
// Self-checking bench for meta_write_responder. The main process issues
// directed and then random requests and checks the handshake timing of each
// one. The expected acknowledgement {source, idx} is pushed into a scoreboard
// queue. A separate monitor pops that queue whenever an ack handshake occurs.
// A simple array model of {valid, tag} predicts every lookup.
// Honours META_RESP_BYPASS_EN for the lookup made during the WRITE cycle.

module tb_meta_write_responder;

  localparam int IDX_W = 7;
  localparam int TAG_W = 20;
  localparam int SETS  = 1 << IDX_W;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             in_way_en;
  logic [TAG_W-1:0] in_tag;
  logic [1:0]       in_chosen;
  logic             resp_0_valid, resp_1_valid, resp_2_valid;
  logic [2:0]       resp_ready;
  logic [IDX_W-1:0] resp_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic             busy;
  logic             err;

  int errors = 0;
  int checks = 0;

  // Reference model: plain arrays indexed by set, plus the sticky error flag.
  bit               ref_valid [SETS];
  logic [TAG_W-1:0] ref_tag   [SETS];
  bit               ref_err;

  // Scoreboard entries are {source id, idx}.
  logic [IDX_W+1:0] sb_q [$];

  meta_write_responder #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .io_in_valid       (in_valid),
    .io_in_ready       (in_ready),
    .io_in_bits_idx    (in_idx),
    .io_in_bits_way_en (in_way_en),
    .io_in_bits_tag    (in_tag),
    .io_in_chosen      (in_chosen),
    .io_resp_0_valid   (resp_0_valid),
    .io_resp_1_valid   (resp_1_valid),
    .io_resp_2_valid   (resp_2_valid),
    .io_resp_0_ready   (resp_ready[0]),
    .io_resp_1_ready   (resp_ready[1]),
    .io_resp_2_ready   (resp_ready[2]),
    .io_resp_bits_idx  (resp_idx),
    .io_rd_idx         (rd_idx),
    .io_rd_valid       (rd_valid),
    .io_rd_tag         (rd_tag),
    .io_busy           (busy),
    .io_err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison. Every check in the bench goes through here.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives a lookup and compares it with the model. The tag is compared
  // only for valid entries, because tags are not reset.
  task automatic check_read(input logic [IDX_W-1:0] idx, input string name);
    rd_idx = idx;
    #1;
    check_output({name, "_valid"}, 32'(rd_valid), 32'(ref_valid[idx]));
    if (ref_valid[idx]) check_output({name, "_tag"}, 32'(rd_tag), 32'(ref_tag[idx]));
  endtask

  task automatic clear_model();
    for (int i = 0; i < SETS; i++) ref_valid[i] = 1'b0;
    ref_err = 1'b0;
  endtask

  // Issues one request and checks it cycle by cycle. Call it just after a
  // negedge. It returns just after the negedge that follows the
  // acknowledgement, or after the early return to IDLE.
  // 'delay' is the number of RESP cycles that the chosen ready is held low.
  // With 'abort' set, reset is asserted asynchronously in the first RESP cycle.
  task automatic apply_stimulus(input logic [IDX_W-1:0] idx, input logic way_en,
                                input logic [TAG_W-1:0] tag, input logic [1:0] chosen,
                                input int delay, input bit abort);
    bit               exp_v;
    logic [TAG_W-1:0] exp_t;
    check_output("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    in_idx     = idx;
    in_way_en  = way_en;
    in_tag     = tag;
    in_chosen  = chosen;
    resp_ready = 3'b000;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_idx    = IDX_W'($urandom);
    in_tag    = TAG_W'($urandom);
    in_way_en = 1'($urandom);
    in_chosen = 2'($urandom);
    if (chosen != 2'd3) sb_q.push_back({chosen, idx});

    // WRITE cycle
    @(negedge clk);
    check_output("in_ready_write", 32'(in_ready), 32'd0);
    check_output("busy_write", 32'(busy), 32'd1);
    check_output("resp_valid_write", 32'({resp_2_valid, resp_1_valid, resp_0_valid}), 32'd0);
    rd_idx = idx;
    #1;
    exp_v = ref_valid[idx];
    exp_t = ref_tag[idx];
`ifdef META_RESP_BYPASS_EN
    if (way_en) begin
      exp_v = 1'b1;
      exp_t = tag;
    end
`endif
    check_output("rd_valid_during_write", 32'(rd_valid), 32'(exp_v));
    if (exp_v) check_output("rd_tag_during_write", 32'(rd_tag), 32'(exp_t));
    @(posedge clk);
    if (way_en) begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tag;
    end
    @(negedge clk);

    if (chosen == 2'd3) begin
      ref_err = 1'b1;
      check_output("err_after_bad_src", 32'(err), 32'd1);
      check_output("busy_after_bad_src", 32'(busy), 32'd0);
      check_output("in_ready_after_bad_src", 32'(in_ready), 32'd1);
      check_output("no_ack_bad_src", 32'({resp_2_valid, resp_1_valid, resp_0_valid}), 32'd0);
      return;
    end

    for (int k = 0; k <= delay; k++) begin
      check_output("resp_valid_vec", 32'({resp_2_valid, resp_1_valid, resp_0_valid}),
                   32'(3'b001 << chosen));
      check_output("resp_idx_held", 32'(resp_idx), 32'(idx));
      check_output("in_ready_resp", 32'(in_ready), 32'd0);
      if (abort) begin
        #3;
        reset_n = 1'b0;
        #1;
        check_output("rst_resp_valid", 32'({resp_2_valid, resp_1_valid, resp_0_valid}), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_resp_idx", 32'(resp_idx), 32'd0);
        sb_q.delete();
        clear_model();
        check_read(7'h15, "rst_rd_15");
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      // Readies of the other sources are randomised to show they are ignored.
      resp_ready = 3'($urandom);
      resp_ready[chosen] = (k == delay);
      @(negedge clk);
    end
    resp_ready = 3'b000;
    check_output("busy_after_ack", 32'(busy), 32'd0);
    check_output("in_ready_after_ack", 32'(in_ready), 32'd1);
    check_output("resp_valid_after_ack", 32'({resp_2_valid, resp_1_valid, resp_0_valid}), 32'd0);
    check_output("err_sticky", 32'(err), 32'(ref_err));
  endtask

  // Monitor: any ack handshake must match the oldest outstanding request.
  initial begin
    logic [2:0]       vld;
    logic [IDX_W+1:0] exp;
    forever begin
      @(negedge clk);
      #2;
      vld = {resp_2_valid, resp_1_valid, resp_0_valid};
      if (reset_n && (vld & resp_ready) != 3'b000) begin
        if (sb_q.size() == 0) begin
          check_output("unexpected_ack", 32'(vld), 32'd0);
        end else begin
          exp = sb_q.pop_front();
          check_output("ack_source", 32'(vld), 32'(3'b001 << exp[IDX_W+1:IDX_W]));
          check_output("ack_idx", 32'(resp_idx), 32'(exp[IDX_W-1:0]));
        end
      end
    end
  end

  initial begin
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_src;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_idx     = '0;
    in_way_en  = 1'b0;
    in_tag     = '0;
    in_chosen  = 2'd0;
    resp_ready = 3'b000;
    rd_idx     = '0;
    clear_model();
    for (int i = 0; i < SETS; i++) ref_tag[i] = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset state");
    check_output("reset_in_ready", 32'(in_ready), 32'd1);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_err", 32'(err), 32'd0);
    check_output("reset_resp_valid", 32'({resp_2_valid, resp_1_valid, resp_0_valid}), 32'd0);
    check_output("reset_resp_idx", 32'(resp_idx), 32'd0);
    for (int i = 0; i < SETS; i++) check_read(IDX_W'(i), "reset_sweep");
    @(negedge clk);

    $display("[TB] directed requests");
    apply_stimulus(7'h15, 1'b1, 20'hABCDE, 2'd1, 0, 1'b0);
    check_read(7'h15, "rd_15_after_write");
    apply_stimulus(7'h15, 1'b0, 20'h11111, 2'd2, 10, 1'b0);
    check_read(7'h15, "rd_15_after_noop");
    apply_stimulus(7'h7F, 1'b1, 20'h12345, 2'd0, 1, 1'b0);
    check_read(7'h7F, "rd_7f_after_write");
    apply_stimulus(7'h20, 1'b1, 20'h55555, 2'd3, 0, 1'b0);
    check_read(7'h20, "rd_20_bad_src");
    apply_stimulus(7'h21, 1'b1, 20'h0F0F0, 2'd2, 2, 1'b0);

    $display("[TB] random requests");
    for (int n = 0; n < 40; n++) begin
      r_idx = ($urandom_range(0, 1) == 0) ? IDX_W'($urandom_range(16, 23)) : IDX_W'($urandom);
      r_src = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      apply_stimulus(r_idx, 1'($urandom), TAG_W'($urandom), r_src, $urandom_range(0, 4), 1'b0);
      for (int j = 0; j < 3; j++) check_read(IDX_W'($urandom_range(16, 23)), "rd_random");
      check_read(r_idx, "rd_random_last");
      @(negedge clk);
    end

    $display("[TB] reset during RESP");
    apply_stimulus(7'h33, 1'b1, 20'h2468A, 2'd1, 5, 1'b1);
    @(negedge clk);
    check_read(7'h33, "rd_33_after_reset");
    apply_stimulus(7'h15, 1'b1, 20'hBEEF1, 2'd0, 0, 1'b0);
    check_read(7'h15, "rd_15_after_recovery");

    repeat (2) @(negedge clk);
    check_output("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
